// File: rtl/johnson_step_ctrl.sv
// rtl/johnson_step_ctrl.sv - Johnson counter stepped in bounded runs with pause/stop/load control.
// Optional JOHNSON_SELFCORRECT_EN: illegal counter patterns are forced to 0000 on the next advance.
module johnson_step_ctrl #(
  parameter int STEP_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [STEP_W-1:0] steps,
  input  logic              dir,
  input  logic              pause,
  input  logic              stop,
  input  logic              load,
  input  logic [3:0]        load_val,
  output logic [3:0]        out,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] remaining,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_out;
  logic [3:0]        w_out_nxt;
  logic [STEP_W-1:0] r_rem;
  logic [STEP_W-1:0] w_rem_nxt;
  logic              r_dir;
  logic              w_dir_nxt;
  logic              r_err;
  logic              w_err_nxt;

  logic [3:0]        w_up;
  logic [3:0]        w_dn;
  logic [3:0]        w_adv;
  logic              w_fix;
  logic              w_last;

  assign w_up   = {~r_out[0], r_out[3:1]};
  assign w_dn   = {r_out[2:0], ~r_out[3]};
  assign w_adv  = r_dir ? w_up : w_dn;
  assign w_last = (r_rem == STEP_W'(1));

`ifdef JOHNSON_SELFCORRECT_EN
  logic w_legal;

  always_comb begin
    w_legal = 1'b0;
    case (r_out)
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001: w_legal = 1'b1;
      default:                            w_legal = 1'b0;
    endcase
  end

  assign w_fix = ~w_legal;
`else
  assign w_fix = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PAUSE is left on the same edge that performs the next advance, so pause only costs the held cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_rem_nxt   = r_rem;
    w_dir_nxt   = r_dir;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_out_nxt = load_val;
        end else if (start) begin
          if (steps != '0) begin
            w_rem_nxt   = steps;
            w_dir_nxt   = dir;
            w_state_nxt = S_RUN;
          end else begin
            w_rem_nxt   = '0;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN, S_PAUSE: begin
        if (stop) begin
          w_rem_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (pause) begin
          w_state_nxt = S_PAUSE;
        end else begin
          w_out_nxt   = w_fix ? 4'b0000 : w_adv;
          w_err_nxt   = w_fix;
          w_rem_nxt   = r_rem - STEP_W'(1);
          w_state_nxt = w_last ? S_DONE : S_RUN;
        end
      end
      S_DONE: begin
        w_rem_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= 4'b0000;
      r_rem <= '0;
      r_dir <= 1'b1;
      r_err <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      r_rem <= w_rem_nxt;
      r_dir <= w_dir_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign out       = r_out;
  assign remaining = r_rem;
  assign busy      = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;

endmodule
